// File: rtl/bus_mem_6502_pkg.sv
// Shared types and constants for the bus_mem_6502 memory/bus responder.
package bus_mem_6502_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    TX   = 2'd2,
    HALT = 2'd3
  } state_e;

  localparam logic [15:0] DEF_IO_ADDR   = 16'hF001;
  localparam logic [15:0] DEF_HALT_ADDR = 16'hF00F;

  localparam int unsigned CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/bus_mem_6502_ram.sv
// Byte-wide synchronous single-port RAM with read-before-write.
module bus_mem_6502_ram
  import bus_mem_6502_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter string       MEM_FILE = ""
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem [0:(2**ADDR_W)-1];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem[addr_i];
      if (we_i) mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_6502.sv
// Memory and bus responder for cpu_6502: wait states, console port, halt mailbox.
// Optional write-protect window enabled by defining BUS_MEM_6502_ROM_WP_EN.
module bus_mem_6502
  import bus_mem_6502_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [15:0] IO_ADDR     = DEF_IO_ADDR,
  parameter logic [15:0] HALT_ADDR   = DEF_HALT_ADDR,
  parameter logic [15:0] ROM_BASE    = 16'hE000,
  parameter logic [15:0] ROM_LIMIT   = 16'hFFFF,
  parameter string       MEM_FILE    = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ab,
  input  logic [7:0]        wdata,
  input  logic              we,
  output logic [7:0]        rdata,
  output logic              rdy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done,
  output logic [7:0]        done_code,
  output logic              rom_wr_err
);

`ifdef BUS_MEM_6502_ROM_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] IO_A   = ADDR_W'(IO_ADDR);
  localparam logic [ADDR_W-1:0] HALT_A = ADDR_W'(HALT_ADDR);
  // Window compared one bit wider so a limit at the top of the map is not a constant-true test.
  localparam logic [ADDR_W:0]   ROM_LO = (ADDR_W+1)'(ROM_BASE);
  localparam logic [ADDR_W:0]   ROM_HI = (ADDR_W+1)'(ROM_LIMIT);
  localparam cnt_t              WAIT_LD  = cnt_t'(WAIT_CYCLES);
  localparam state_e            RESET_ST = (WAIT_CYCLES == 0) ? RUN : WAIT;

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       done_q, done_d;
  logic [7:0] code_q, code_d;
  logic       rom_err_q, rom_err_d;
  logic       sel_ram_q, sel_ram_d;

  logic       is_io, is_halt, in_rom, ram_en, ram_we;
  logic [7:0] ram_rdata;
  logic [ADDR_W:0] ab_x;

  assign rdy     = (state_q == RUN) && !reset;
  assign is_io   = (ab == IO_A);
  assign is_halt = (ab == HALT_A);
  assign ab_x    = {1'b0, ab};
  assign in_rom  = WP_EN && (ab_x >= ROM_LO) && (ab_x <= ROM_HI);
  assign ram_en  = rdy && !is_io && !is_halt;
  assign ram_we  = ram_en && we && !in_rom;

  bus_mem_6502_ram #(
    .ADDR_W   (ADDR_W),
    .MEM_FILE (MEM_FILE)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ab),
    .wdata_i (wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = done_q;
    code_d     = code_q;
    rom_err_d  = rom_err_q;
    sel_ram_d  = sel_ram_q;
    unique case (state_q)
      RUN: begin
        if (rdy) begin
          sel_ram_d = ram_en;
          if (ram_en && we && in_rom) rom_err_d = 1'b1;
          if (we && is_io) begin
            tx_data_d  = wdata;
            tx_valid_d = 1'b1;
            state_d    = TX;
          end else if (we && is_halt) begin
            done_d  = 1'b1;
            code_d  = wdata;
            state_d = HALT;
          end else if (WAIT_CYCLES != 0) begin
            cnt_d   = WAIT_LD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= cnt_t'(1)) state_d = RUN;
        else                    cnt_d   = cnt_q - cnt_t'(1);
      end
      TX: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          if (WAIT_CYCLES != 0) begin
            cnt_d   = WAIT_LD;
            state_d = WAIT;
          end else begin
            state_d = RUN;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = RESET_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_ST;
      cnt_q      <= WAIT_LD;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      code_q     <= '0;
      rom_err_q  <= 1'b0;
      sel_ram_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      code_q     <= code_d;
      rom_err_q  <= rom_err_d;
      sel_ram_q  <= sel_ram_d;
    end
  end

  // RAM output register holds across stalls; IO/halt reads and reset mask it to zero.
  assign rdata      = sel_ram_q ? ram_rdata : '0;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign done       = done_q;
  assign done_code  = code_q;
  assign rom_wr_err = WP_EN ? rom_err_q : 1'b0;

endmodule

// File: tb/tb_bus_mem_6502.sv
// Directed bench for bus_mem_6502: zero-wait instance plus a three-wait-state instance.
module tb_bus_mem_6502;

  localparam logic [15:0] IO   = 16'hF001;
  localparam logic [15:0] HALT = 16'hF00F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3, we0, we3, txr0, txr3;
  logic [15:0] ab0, ab3;
  logic [7:0]  wd0, wd3;
  logic [7:0]  rdata0, rdata3, txd0, txd3, code0, code3;
  logic        rdy0, rdy3, txv0, txv3, done0, done3, rerr0, rerr3;

  int checks = 0;
  int failures = 0;

  bus_mem_6502 #(.ADDR_W(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst0), .ab(ab0), .wdata(wd0), .we(we0), .rdata(rdata0), .rdy(rdy0),
    .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0), .done(done0), .done_code(code0),
    .rom_wr_err(rerr0));

  bus_mem_6502 #(.ADDR_W(16), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst3), .ab(ab3), .wdata(wd3), .we(we3), .rdata(rdata3), .rdy(rdy3),
    .tx_data(txd3), .tx_valid(txv3), .tx_ready(txr3), .done(done3), .done_code(code3),
    .rom_wr_err(rerr3));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One bus access on the zero-wait instance; sampled 1 time unit after the edge.
  task automatic acc0(input logic [15:0] a, input logic w, input logic [7:0] d);
    @(negedge clk); ab0 = a; we0 = w; wd0 = d;
    @(posedge clk); #1; we0 = 1'b0;
  endtask

  task automatic wait_rdy3(input string name);
    int n = 0;
    while (rdy3 !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL %s: rdy3 got %b required 1 within 20 cycles", name, rdy3); end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst3 = 1'b1; we0 = 0; we3 = 0; txr0 = 0; txr3 = 0;
    ab0 = '0; ab3 = '0; wd0 = '0; wd3 = '0;
    repeat (2) tick();
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_rdy0: got %b required 0", rdy0); end
    checks++; if (rdy3 !== 1'b0) begin failures++; $display("FAIL reset_rdy3: got %b required 0", rdy3); end
    checks++; if (rdata0 !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h required 00", rdata0); end
    checks++; if ({txv0, txd0} !== 9'h000) begin failures++; $display("FAIL reset_tx: got %b/%h required 0/00", txv0, txd0); end
    checks++; if ({done0, code0, rerr0} !== 10'h000) begin failures++; $display("FAIL reset_flags: got %b/%h/%b required 0/00/0", done0, code0, rerr0); end
    @(negedge clk); rst0 = 1'b0; #1;
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL release_rdy0: got %b required 1", rdy0); end
  endtask

  task automatic test_rw();
    acc0(16'h0010, 1'b1, 8'hA5);
    acc0(16'h0011, 1'b1, 8'h3C);
    acc0(16'h0010, 1'b0, 8'h00);
    checks++; if (rdata0 !== 8'hA5) begin failures++; $display("FAIL rw_read10: got %h required a5", rdata0); end
    acc0(16'h0011, 1'b0, 8'h00);
    checks++; if (rdata0 !== 8'h3C) begin failures++; $display("FAIL rw_read11: got %h required 3c", rdata0); end
    acc0(16'h0010, 1'b1, 8'h77);
    checks++; if (rdata0 !== 8'hA5) begin failures++; $display("FAIL rw_old_on_write: got %h required a5", rdata0); end
    acc0(16'h0010, 1'b0, 8'h00);
    checks++; if (rdata0 !== 8'h77) begin failures++; $display("FAIL rw_new: got %h required 77", rdata0); end
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL rw_rdy_const: got %b required 1", rdy0); end
  endtask

  task automatic test_io_read();
    acc0(IO, 1'b0, 8'h00);
    checks++; if (rdata0 !== 8'h00) begin failures++; $display("FAIL io_read: got %h required 00", rdata0); end
    acc0(16'h0010, 1'b0, 8'h00);
    acc0(HALT, 1'b0, 8'h00);
    checks++; if ({rdata0, done0} !== 9'h000) begin failures++; $display("FAIL halt_read: got %h/%b required 00/0", rdata0, done0); end
  endtask

  task automatic test_rom();
    logic [7:0] exp_d;
    logic       exp_e;
`ifdef BUS_MEM_6502_ROM_WP_EN
    exp_d = 8'h11; exp_e = 1'b1;
`else
    exp_d = 8'hFF; exp_e = 1'b0;
`endif
    acc0(16'hE123, 1'b1, 8'hFF);
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL rom_timing: rdy got %b required 1", rdy0); end
    acc0(16'hE123, 1'b0, 8'h00);
    checks++; if (rdata0 !== exp_d) begin failures++; $display("FAIL rom_data: got %h required %h", rdata0, exp_d); end
    checks++; if (rerr0 !== exp_e) begin failures++; $display("FAIL rom_err: got %b required %b", rerr0, exp_e); end
  endtask

  task automatic test_tx();
    txr0 = 1'b0;
    acc0(IO, 1'b1, 8'h4F);
    checks++; if ({txv0, txd0, rdy0} !== {1'b1, 8'h4F, 1'b0}) begin failures++; $display("FAIL tx_start: got v=%b d=%h rdy=%b required 1/4f/0", txv0, txd0, rdy0); end
    ab0 = HALT; we0 = 1'b1; wd0 = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({txv0, txd0, rdy0, done0} !== {1'b1, 8'h4F, 2'b00}) begin failures++; $display("FAIL tx_stall%0d: got v=%b d=%h rdy=%b done=%b required 1/4f/0/0", i, txv0, txd0, rdy0, done0); end
    end
    @(negedge clk); we0 = 1'b0; txr0 = 1'b1;
    tick();
    checks++; if ({txv0, rdy0} !== 2'b01) begin failures++; $display("FAIL tx_handshake: got v=%b rdy=%b required 0/1", txv0, rdy0); end
    acc0(IO, 1'b1, 8'h4B);
    checks++; if ({txv0, txd0} !== {1'b1, 8'h4B}) begin failures++; $display("FAIL tx_second: got v=%b d=%h required 1/4b", txv0, txd0); end
    tick();
    checks++; if ({txv0, rdy0} !== 2'b01) begin failures++; $display("FAIL tx_second_hs: got v=%b rdy=%b required 0/1", txv0, rdy0); end
  endtask

  task automatic test_tx_reset();
    txr0 = 1'b0;
    acc0(IO, 1'b1, 8'h4F);
    checks++; if (txv0 !== 1'b1) begin failures++; $display("FAIL txrst_pending: got %b required 1", txv0); end
    @(negedge clk); rst0 = 1'b1; #1;
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL txrst_rdy: got %b required 0", rdy0); end
    tick();
    checks++; if ({txv0, done0, rerr0} !== 3'b000) begin failures++; $display("FAIL txrst_drop: got v=%b done=%b err=%b required 0/0/0", txv0, done0, rerr0); end
    @(negedge clk); rst0 = 1'b0;
    acc0(IO, 1'b1, 8'h4F);
    checks++; if ({txv0, txd0} !== {1'b1, 8'h4F}) begin failures++; $display("FAIL txrst_reemit: got v=%b d=%h required 1/4f", txv0, txd0); end
    @(negedge clk); txr0 = 1'b1;
    tick();
    checks++; if ({txv0, rdy0} !== 2'b01) begin failures++; $display("FAIL txrst_hs: got v=%b rdy=%b required 0/1", txv0, rdy0); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_top;
`ifdef BUS_MEM_6502_ROM_WP_EN
    exp_top = 8'h00;
`else
    exp_top = 8'hC3;
`endif
    acc0(16'h0000, 1'b1, 8'h12);
    acc0(16'hFFFF, 1'b1, 8'hC3);
    acc0(16'h0000, 1'b0, 8'h00);
    checks++; if (rdata0 !== 8'h12) begin failures++; $display("FAIL wrap_low: got %h required 12", rdata0); end
    acc0(16'hFFFF, 1'b0, 8'h00);
    checks++; if (rdata0 !== exp_top) begin failures++; $display("FAIL wrap_top: got %h required %h", rdata0, exp_top); end
  endtask

  task automatic test_halt();
    acc0(HALT, 1'b1, 8'h5A);
    checks++; if ({done0, code0, rdy0} !== {1'b1, 8'h5A, 1'b0}) begin failures++; $display("FAIL halt_set: got done=%b code=%h rdy=%b required 1/5a/0", done0, code0, rdy0); end
    @(negedge clk); ab0 = HALT; we0 = 1'b1; wd0 = 8'h77;
    repeat (5) tick();
    checks++; if ({done0, code0, rdy0} !== {1'b1, 8'h5A, 1'b0}) begin failures++; $display("FAIL halt_stuck: got done=%b code=%h rdy=%b required 1/5a/0", done0, code0, rdy0); end
    @(negedge clk); we0 = 1'b0; rst0 = 1'b1;
    tick();
    checks++; if ({done0, code0} !== 9'h000) begin failures++; $display("FAIL halt_reset: got done=%b code=%h required 0/00", done0, code0); end
    @(negedge clk); rst0 = 1'b0; #1;
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL halt_exit: rdy got %b required 1", rdy0); end
  endtask

  task automatic test_wait_states();
    logic exp_pat [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk); rst3 = 1'b0; ab3 = 16'h0020; we3 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++; if (rdy3 !== exp_pat[i]) begin failures++; $display("FAIL wait_pat%0d: got %b required %b", i, rdy3, exp_pat[i]); end
    end
    @(negedge clk); we3 = 1'b1; wd3 = 8'h99;
    tick(); we3 = 1'b0;
    wait_rdy3("wait_wr_done");
    tick();
    checks++; if ({rdata3, rdy3} !== {8'h99, 1'b0}) begin failures++; $display("FAIL wait_read: got %h rdy=%b required 99/0", rdata3, rdy3); end
    ab3 = 16'h0021;
    repeat (2) tick();
    checks++; if ({rdata3, rdy3} !== {8'h99, 1'b0}) begin failures++; $display("FAIL wait_hold: got %h rdy=%b required 99/0", rdata3, rdy3); end
    tick();
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL wait_return: got %b required 1", rdy3); end
    @(negedge clk); ab3 = IO; we3 = 1'b1; wd3 = 8'h4B; txr3 = 1'b1;
    tick(); we3 = 1'b0;
    checks++; if ({txv3, txd3, rdy3} !== {1'b1, 8'h4B, 1'b0}) begin failures++; $display("FAIL wait_tx: got v=%b d=%h rdy=%b required 1/4b/0", txv3, txd3, rdy3); end
    tick();
    checks++; if ({txv3, rdy3} !== 2'b00) begin failures++; $display("FAIL wait_tx_hs: got v=%b rdy=%b required 0/0", txv3, rdy3); end
    repeat (2) tick();
    checks++; if (rdy3 !== 1'b0) begin failures++; $display("FAIL wait_tx_stall: got %b required 0", rdy3); end
    tick();
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL wait_tx_return: got %b required 1", rdy3); end
  endtask

  initial begin
    // Preload cells that the write-protect scenarios must find untouched.
    u_dut0.u_ram.mem[16'hE123] = 8'h11;
    u_dut0.u_ram.mem[16'hFFFF] = 8'h00;
    test_reset();
    test_rw();
    test_io_read();
    test_rom();
    test_tx();
    test_tx_reset();
    test_wrap();
    test_halt();
    test_wait_states();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
